page_fifo_wconv: RTL

//  Single-clock, multi-page buffer with write/read width conversion; parametrised successor to the SDRAM->USB page buffer.

---
 rtl/page_fifo_pkg.sv | 29 ++
 rtl/sdp_ram.sv | 35 +++
 rtl/page_fifo_wconv.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/page_fifo_pkg.sv
// Shared helpers for the paged width-converting FIFO: log2 and parameter legality.
package page_fifo_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result++;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  // Write word must split into a power-of-two number of read lanes.
  function automatic bit widths_legal(input int unsigned wr_width, input int unsigned rd_width);
    if (rd_width == 0 || wr_width < rd_width) return 1'b0;
    if ((wr_width % rd_width) != 0) return 1'b0;
    return is_pow2(wr_width / rd_width);
  endfunction

  function automatic int unsigned lane_bits(input int unsigned wr_width,
                                            input int unsigned rd_width);
    return clog2(wr_width / rd_width);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read (old data on collision).
module sdp_ram #(
  parameter int unsigned Width = 8,
  parameter int unsigned Aw    = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem [2**Aw];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/page_fifo_wconv.sv
// Multi-page buffer: producer fills and commits pages of wide words, consumer reads
// committed pages byte-addressed and releases them. Tracks occupancy and sticky errors.
module page_fifo_wconv
  import page_fifo_pkg::*;
#(
  parameter int unsigned WR_WIDTH   = 16,
  parameter int unsigned RD_WIDTH   = 8,
  parameter int unsigned PAGE_AW    = 5,
  parameter int unsigned PAGES_LOG2 = 2,
  localparam int unsigned RATIO     = WR_WIDTH / RD_WIDTH,
  localparam int unsigned LANE_BITS = lane_bits(WR_WIDTH, RD_WIDTH),
  localparam int unsigned RD_AW     = PAGE_AW + LANE_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PAGE_AW-1:0]    wr_addr,
  input  logic [WR_WIDTH-1:0]   wr_data,
  input  logic                  wr_en,
  input  logic                  wr_push,
  output logic                  wr_full,
  input  logic [RD_AW-1:0]      rd_addr,
  output logic [RD_WIDTH-1:0]   rd_data,
  input  logic                  rd_pull,
  output logic                  rd_empty,
  output logic [PAGES_LOG2:0]   pages_used,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam int unsigned PAGES  = 2 ** PAGES_LOG2;
  localparam int unsigned RAM_AW = PAGES_LOG2 + PAGE_AW;

  localparam logic [PAGES_LOG2:0]   COUNT_MAX = (PAGES_LOG2 + 1)'(PAGES);
  localparam logic [PAGES_LOG2:0]   COUNT_ONE = (PAGES_LOG2 + 1)'(1);
  localparam logic [PAGES_LOG2-1:0] PTR_ONE   = PAGES_LOG2'(1);

  if (!widths_legal(WR_WIDTH, RD_WIDTH) || PAGES_LOG2 < 1 || PAGE_AW < 1) begin : g_param_err
    $error("page_fifo_wconv: illegal WR_WIDTH/RD_WIDTH/PAGES_LOG2/PAGE_AW combination");
  end

  logic [PAGES_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [PAGES_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [PAGES_LOG2:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic pull_ok;
  logic push_ok;

  // A pull on the same edge frees the head page, so a push against a full buffer is legal.
  always_comb begin
    pull_ok  = rd_pull && !empty_q;
    push_ok  = wr_push && (!full_q || pull_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (wr_push && !push_ok);
    unf_d    = unf_q | (rd_pull && !pull_ok);

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pull_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    case ({push_ok, pull_ok})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == COUNT_MAX);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign wr_full       = full_q;
  assign rd_empty      = empty_q;
  assign pages_used    = count_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

  // Storage: one RAM per read lane, all sharing the write and read word addresses.
  logic              ram_we;
  logic [RAM_AW-1:0] ram_waddr;
  logic [RAM_AW-1:0] ram_raddr;
  logic [RD_WIDTH-1:0] lane_rdata [RATIO];

  assign ram_we    = wr_en && !full_q;
  assign ram_waddr = {wr_ptr_q, wr_addr};
  assign ram_raddr = {rd_ptr_q, rd_addr[RD_AW-1:LANE_BITS]};

  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    sdp_ram #(
      .Width (RD_WIDTH),
      .Aw    (RAM_AW)
    ) u_ram (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (wr_data[g*RD_WIDTH +: RD_WIDTH]),
      .raddr_i (ram_raddr),
      .rdata_o (lane_rdata[g])
    );
  end

  // Lane select is delayed to line up with the registered RAM output.
  if (LANE_BITS > 0) begin : g_lane_mux
    logic [LANE_BITS-1:0] lane_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_q <= '0;
      end else begin
        lane_q <= rd_addr[LANE_BITS-1:0];
      end
    end

    assign rd_data = lane_rdata[lane_q];
  end else begin : g_lane_single
    assign rd_data = lane_rdata[0];
  end

endmodule
